// File: rtl/goomba_gravity_mover_pkg.sv
// Shared game definitions: tile codes, screen/tile geometry, map shape,
// the vertical-mover state type and the tile-row helper.
package game_pkg;

    typedef enum byte {
        BDR = 8'sd0,
        SKY = 8'sd1,
        BLK = 8'sd2,
        GND = 8'sd3
    } tile_t;

    localparam int CHARACTER_WIDTH = 42;
    localparam int SCREEN_WIDTH    = 640;
    localparam int SCREEN_HEIGHT   = 480;
    localparam int BLOCK_WIDTH     = 40;
    localparam int MAP_ROWS        = 12;
    localparam int MAP_COLS        = 17;

    // Tile map, indexed [row][col]; each entry holds a tile_t code.
    typedef logic [MAP_ROWS-1:0][MAP_COLS-1:0][7:0] tile_map_t;

    typedef enum logic [1:0] {
        RESET    = 2'd0,
        GROUNDED = 2'd1,
        FALLING  = 2'd2,
        OUT      = 2'd3
    } mover_state_t;

    // Tile row containing the pixel line just below the sprite's feet.
    function automatic int row_at(input int y);
        return (y + CHARACTER_WIDTH) / BLOCK_WIDTH;
    endfunction

endpackage

// File: rtl/goomba_gravity_mover_if.sv
// Signal bundle between the goomba vertical mover and its neighbours.
//   background : tile map [row][col]
//   goomba_x   : goomba left edge (from the left/right mover)
//   freeze     : hold all motion
//   goomba_y   : goomba top edge
//   falling    : goomba is airborne
//   fell_out   : sticky, goomba left through the bottom of the screen
// master drives the map/x/freeze side, slave is the mover itself.
interface goomba_gravity_mover_if;
    import game_pkg::*;

    tile_map_t background;
    int        goomba_x;
    logic      freeze;
    int        goomba_y;
    logic      falling;
    logic      fell_out;

    modport master (
        output background, goomba_x, freeze,
        input  goomba_y, falling, fell_out
    );

    modport slave (
        input  background, goomba_x, freeze,
        output goomba_y, falling, fell_out
    );

endinterface

// File: rtl/goomba_gravity_mover_tile_probe.sv
// Combinational support probe: is there a solid tile directly under a
// sprite whose left edge is x and top edge is y?
//   background : tile map [row][col]
//   x, y       : sprite left/top edge in pixels
//   supported  : a BLK or GND tile lies under the left or right foot column
// Anything outside the map (or a negative x) counts as not solid.
module tile_probe
    import game_pkg::*;
(
    input  tile_map_t background,
    input  int        x,
    input  int        y,
    output logic      supported
);

    int col_l;
    int col_r;
    int row;

    function automatic logic is_solid(input tile_map_t bg, input int r, input int c);
        logic [7:0] t;
        logic [3:0] ri;
        logic [4:0] ci;
        ri = r[3:0];
        ci = c[4:0];
        t  = 8'(SKY);
        if (r >= 0 && r < MAP_ROWS && c >= 0 && c < MAP_COLS) begin
            t = bg[ri][ci];
        end
        return (t == 8'(BLK)) || (t == 8'(GND));
    endfunction

    always_comb begin
        col_l     = x / BLOCK_WIDTH;
        col_r     = (x + CHARACTER_WIDTH - 1) / BLOCK_WIDTH;
        row       = row_at(y);
        supported = (x >= 0) &&
                    (is_solid(background, row, col_l) || is_solid(background, row, col_r));
    end

endmodule

// File: rtl/goomba_gravity_mover.sv
// Vertical-motion stage for one goomba: tile-based gravity with a ramping
// fall speed, snap-to-tile landing, and off-screen retirement.
//   movement_clock : movement tick clock
//   reset          : synchronous active-low reset
//   mv             : slave side of goomba_gravity_mover_if
//                    (background, goomba_x, freeze in; goomba_y, falling,
//                    fell_out out, all registered)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RESET    | just reset; y = STARTY, goes to GROUNDED on the next tick
// GROUNDED | standing; leaves for FALLING when the feet lose support
// FALLING  | airborne; moves down by vel each tick, speeds up every
//          | GRAVITY_DIVIDER ticks up to MAX_FALL_SPEED
// OUT      | fell past the screen bottom; parked at OFFSCREEN_Y until reset
module goomba_gravity_mover
    import game_pkg::*;
#(
    parameter int STARTY          = 398,
    parameter int GRAVITY_DIVIDER = 4,
    parameter int MAX_FALL_SPEED  = 8,
    parameter int OFFSCREEN_Y     = 1000
) (
    input  logic                    movement_clock,
    input  logic                    reset,
    goomba_gravity_mover_if.slave   mv
);

    mover_state_t state_q, state_d;
    int           y_q, y_d;
    int           vel_q, vel_d;
    int           tick_q, tick_d;
    logic         falling_q, falling_d;
    logic         fell_out_q, fell_out_d;

    int           ny;
    logic         sup_here;
    logic         sup_next;

    assign ny = y_q + vel_q;

    tile_probe u_probe_here (
        .background (mv.background),
        .x          (mv.goomba_x),
        .y          (y_q),
        .supported  (sup_here)
    );

    // Candidate position for this tick; vel < BLOCK_WIDTH means at most one
    // row boundary is crossed, so probing ny alone cannot tunnel a tile.
    tile_probe u_probe_next (
        .background (mv.background),
        .x          (mv.goomba_x),
        .y          (ny),
        .supported  (sup_next)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        tick_d  = tick_q;

        // freeze holds everything except the one-shot exit from RESET
        if (!mv.freeze || state_q == RESET) begin
            case (state_q)
                RESET: begin
                    state_d = GROUNDED;
                end
                GROUNDED: begin
                    if (!sup_here) begin
                        state_d = FALLING;
                        vel_d   = 1;
                        tick_d  = 0;
                    end
                end
                FALLING: begin
                    if (sup_next) begin
                        y_d     = row_at(ny) * BLOCK_WIDTH - CHARACTER_WIDTH;
                        vel_d   = 0;
                        tick_d  = 0;
                        state_d = GROUNDED;
                    end else if (ny >= SCREEN_HEIGHT) begin
                        y_d     = OFFSCREEN_Y;
                        state_d = OUT;
                    end else begin
                        y_d = ny;
                        if (tick_q == GRAVITY_DIVIDER - 1) begin
                            tick_d = 0;
                            vel_d  = (vel_q < MAX_FALL_SPEED) ? vel_q + 1 : MAX_FALL_SPEED;
                        end else begin
                            tick_d = tick_q + 1;
                        end
                    end
                end
                OUT: begin
                    y_d = OFFSCREEN_Y;
                end
                default: begin
                    state_d = RESET;
                end
            endcase
        end

        falling_d  = (state_d == FALLING);
        fell_out_d = (state_d == OUT);
    end

    always_ff @(posedge movement_clock) begin
        if (!reset) begin
            state_q    <= RESET;
            y_q        <= STARTY;
            vel_q      <= 0;
            tick_q     <= 0;
            falling_q  <= 1'b0;
            fell_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            vel_q      <= vel_d;
            tick_q     <= tick_d;
            falling_q  <= falling_d;
            fell_out_q <= fell_out_d;
        end
    end

    assign mv.goomba_y = y_q;
    assign mv.falling  = falling_q;
    assign mv.fell_out = fell_out_q;

endmodule
